// File: rtl/wb_dma_master_if.sv
// Pipelined Wishbone bus bundle between the block-copy initiator and its slave.
interface wb_dma_master_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  stall, ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output stall, ack, err, dat_r
    );
endinterface

// File: rtl/wb_dma_master.sv
// Word-by-word Wishbone block copier: one read then one write per word, one access in flight.
// Optional ack-wait watchdog is built when WB_DMA_TIMEOUT_EN is defined.
module wb_dma_master #(
    parameter int unsigned LEN_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] xfer_cnt_o,
    wb_dma_master_if.master      wb
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait,
        StFin
    } state_e;

    state_e               state_q, state_d;
    logic [29:0]          src_q, src_d;
    logic [29:0]          dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          data_q, data_d;
    logic                 err_q, err_d;
    logic                 abort;

    logic        cyc, stb, we;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;

    // Byte-offset bits are dropped: all accesses are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr_i[1:0], dst_addr_i[1:0]};

`ifdef WB_DMA_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [ToW-1:0] to_q, to_d;
    logic           to_hit;

    // Held at zero outside the wait states, so it restarts on every wait entry.
    always_comb begin
        to_d = '0;
        if (state_q == StRdWait || state_q == StWrWait) begin
            to_d = to_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end

    assign to_hit = (to_q == ToW'(TIMEOUT_CYCLES - 1));
    assign abort  = wb.err | to_hit;
`else
    assign abort  = wb.err;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        cyc     = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        adr     = '0;
        dat_w   = '0;
        sel     = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (len_i == '0) begin
                        state_d = StFin;
                    end else begin
                        src_d   = src_addr_i[31:2];
                        dst_d   = dst_addr_i[31:2];
                        len_d   = len_i;
                        state_d = StRdReq;
                    end
                end
            end
            StRdReq: begin
                cyc = 1'b1;
                stb = 1'b1;
                adr = {src_q, 2'b00};
                sel = 4'hF;
                if (!wb.stall) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                cyc = 1'b1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else if (wb.ack) begin
                    data_d  = wb.dat_r;
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                cyc   = 1'b1;
                stb   = 1'b1;
                we    = 1'b1;
                adr   = {dst_q, 2'b00};
                dat_w = data_q;
                sel   = 4'hF;
                if (!wb.stall) begin
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                cyc = 1'b1;
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end else if (wb.ack) begin
                    cnt_d   = cnt_q + 1'b1;
                    src_d   = src_q + 30'd1;
                    dst_d   = dst_q + 30'd1;
                    state_d = ((cnt_q + 1'b1) == len_q) ? StFin : StRdReq;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign busy_o     = (state_q == StRdReq) || (state_q == StRdWait) ||
                        (state_q == StWrReq) || (state_q == StWrWait);
    assign done_o     = (state_q == StFin);
    assign err_o      = err_q;
    assign xfer_cnt_o = cnt_q;

    assign wb.cyc   = cyc;
    assign wb.stb   = stb;
    assign wb.we    = we;
    assign wb.adr   = adr;
    assign wb.dat_w = dat_w;
    assign wb.sel   = sel;

endmodule

// File: doc/wb_dma_master.md
Name: wb_dma_master

Overview:
- Wishbone initiator. Copies a block of 32-bit words from a source address to a destination address over one pipelined-Wishbone master port.
- Targets the on-chip dual-port RAM and peripherals. The core or a debug/boot agent uses it for memory fills and moves without spending CPU cycles.
- One transaction outstanding at a time. Each word is a read, then a write.

Parameters:
- LEN_WIDTH, 16, width of the word-count input and progress counter.
- TIMEOUT_CYCLES, 255, ack-wait limit in clocks; used only with WB_DMA_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- src_addr_i  in  32  source byte address; bits [1:0] ignored (forced 0).
- dst_addr_i  in  32  destination byte address; bits [1:0] ignored (forced 0).
- len_i  in  LEN_WIDTH  number of words to copy.
- busy_o  out  1  high from the cycle after an accepted start until the done pulse.
- done_o  out  1  one-cycle pulse at end of transfer (normal or aborted).
- err_o  out  1  sticky abort flag; cleared by the next accepted start.
- xfer_cnt_o  out  LEN_WIDTH  words fully written so far.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte select; always 4'hF during strobe.
- wb_stall_i  in  1  slave stall.
- wb_ack_i  in  1  slave ack.
- wb_dat_i  in  32  read data.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge):
  - All outputs are 0; FSM goes to IDLE.
  - Reset mid-transfer drops cyc/stb at that edge. No done pulse is issued.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - start_i=1 with len_i=0 → FIN. No bus activity; err_o cleared.
  - start_i=1 with len_i>0 → latch src/dst/len, clear xfer_cnt_o and err_o, go to RD_REQ.
- RD_REQ:
  - cyc=1, stb=1, we=0, adr=current src.
  - stb held, with adr/we stable, while wb_stall_i=1.
  - stall=0 at the edge → RD_WAIT.
- RD_WAIT:
  - cyc=1, stb=0.
  - ack → capture wb_dat_i into the data register and go to WR_REQ.
- WR_REQ:
  - cyc=1, stb=1, we=1, adr=current dst, dat=captured word.
  - Same stall rule as RD_REQ; → WR_WAIT.
- WR_WAIT:
  - ack → xfer_cnt_o+1, src+4, dst+4.
  - Then if xfer_cnt_o+1==len → FIN, else → RD_REQ.
- cyc stays high across consecutive words. It drops only on entry to FIN.
- FIN: done_o=1 for one cycle, busy_o=0, then → IDLE.
- Latency against a zero-stall slave that acks on the clock after stb: 4 clocks per word. done_o appears one clock after the last write ack.
- Addresses wrap modulo 2^32; there is no boundary check.
- Error handling:
  - wb_err_i in any WAIT state → err_o=1, cyc/stb drop next edge, → FIN. xfer_cnt_o is not incremented for that word.
  - err and ack asserted together: err wins.
- start_i while busy is ignored.
- ack/err seen while in a REQ state or in IDLE is ignored.

Optional Feature:
- Macro: WB_DMA_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to each WAIT state and increments each clock while waiting.
  - Reaching TIMEOUT_CYCLES without ack/err → treated as a bus error (err_o=1, abort, FIN).
- Without the macro: no counter, and the FSM waits indefinitely for ack/err.

Test Plan:
- Memory preloaded 0x100..0x10C with 0x11111111,0x22222222,0x33333333,0x44444444; start src=0x100 dst=0x200 len=4 → 0x200..0x20C match the source, done_o exactly 16 clocks after busy_o rises, xfer_cnt_o=4, err_o=0.
- Slave stalls 3 cycles on the first read strobe → stb/adr=0x100 stay stable for 4 clocks, data is still copied correctly, total latency +3.
- len=0 start → done_o the next cycle, wb_cyc_o never asserts, xfer_cnt_o=0.
- wb_err_i on the write of word 2 (len=4) → err_o=1, done_o pulse, xfer_cnt_o=1, dst+4 unchanged.
- wb_rst_ni low during RD_WAIT → next edge all outputs 0; after release, a new start with len=1 completes normally.
- WB_DMA_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → err_o=1 and done_o 8 clocks after entering RD_WAIT. Without the macro, busy_o stays high.
